fpc_gen: RTL and testbench
==========================

// Module: fpc_gen
// PURPOSE
//  Parametrised frame position counter. Successor to the fixed 4x1041 counter.
//  Tracks row/column of the current beat within a ROWS x COLS frame for mapper (MAP_MODE=1)
//  or demapper (MAP_MODE=0) datapaths. Adds a multiframe counter, an external frame-alignment
//  load (i_sync) and position decodes. Sits beside the mapper/demapper to steer OH vs payload beats.
// PARAMETERS
//  ROWS      4     rows per frame (>=2)
//  COLS      1041  columns per row (> OH_COLS+1); last column COLS-1 is the justification column
//  OH_COLS   16    overhead columns 0..OH_COLS-1
//  MAP_MODE  1     1 = map (OH/justification beats free-run), 0 = demap (advance on valid only)
//  MFAS_W    8     multiframe counter width
//  Derived: ROW_W = max(1,$clog2(ROWS)), COL_W = $clog2(COLS)  (11 at default)
// PORTS
//  i_clk          in   1       clock
//  i_rst          in   1       reset, asynchronous, active-high
//  i_enable       in   1       global count enable
//  i_valid        in   1       payload beat valid
//  i_sync         in   1       frame alignment: current beat is row 0 col 0
//  o_row_cnt      out  ROW_W   current row
//  o_col_cnt      out  COL_W   current column
//  o_mfas         out  MFAS_W  multiframe count
//  o_adv          out  1       counter advances at next edge
//  o_oh           out  1       o_col_cnt < OH_COLS
//  o_sof          out  1       row 0 col 0
//  o_eof          out  1       row ROWS-1 col COLS-1
//  o_sync_err     out  1       1-cycle pulse: i_sync seen while not at row 0 col 0
// BEHAVIOUR
//  - Reset (async, immediate): row=0, col=0, mfas=0, o_sync_err=0. Decodes follow: o_sof=1, o_oh=1, o_eof=0.
//  - Free-run column: col<OH_COLS or col==COLS-1.
//  - o_adv (combinational): MAP_MODE=1: i_enable & (i_valid | free-run col); MAP_MODE=0: i_enable & i_valid.
//  - Priority per edge: reset > sync > advance > hold. i_enable=0 holds all state, incl. at frame wrap and on i_sync.
//  - Advance: col<COLS-1 -> col+1; col==COLS-1 -> col=0, row+1; at row ROWS-1,col COLS-1 -> row=0,col=0, mfas+1 (mod 2^MFAS_W).
//  - Sync (i_sync & i_enable): next row=0, col=1 (current beat taken as row0/col0); mfas unchanged.
//    o_sync_err registered, high next cycle iff row!=0 or col!=0 when sync accepted; else 0.
//  - Sync on a not-valid beat in demap mode still loads (aligner owns validity).
//  - o_oh/o_sof/o_eof: pure decodes of registered row/col, no latency beyond counter.
//  - Latency: position updates 1 edge after the qualifying input cycle.
//  - MAP_MODE other than 0/1: elaboration error ($error in generate).
// CONFIGURATION
//  FPC_GEN_SYNC_ERR_CNT_EN defined: adds in i_clr_cnt (1) and out o_sync_err_cnt (16), counting
//    o_sync_err pulses, saturating at 16'hFFFF; reset and i_clr_cnt clear to 0 (clr wins over same-cycle pulse).
//  Undefined: ports and counter absent; o_sync_err unaffected.
// TESTING
//  1 demap, enable=valid=1 for 4164 cycles -> col 0..1040 per row, rows 0..3, wrap to 0/0, mfas 0->1, o_eof at row3/col1040.
//  2 map, enable=1 valid=0 from reset -> col runs 0..16 then holds at 16; valid=1 to col1040, valid=0 -> still advances to row1 col0.
//  3 enable=0 at row3/col1040 with valid=1 and i_sync=1 -> row/col/mfas hold, no o_sync_err.
//  4 i_sync at row2/col500 -> next row0/col1, o_sync_err=1 one cycle, mfas unchanged; i_sync at row0/col0 -> o_sync_err=0.
//  5 i_rst asserted between edges at row1/col700 -> outputs 0 before next edge; release -> counting resumes from 0/0.
//  6 MFAS_W=2, ROWS=2, COLS=20, OH_COLS=4 -> mfas 0,1,2,3,0 over 5 frames; with macro, 3 bad syncs -> o_sync_err_cnt=3, i_clr_cnt -> 0.

Source files
------------

// File: rtl/fpc_gen.sv
// fpc_gen: parametrised ROWS x COLS frame position counter with multiframe count and sync load.
// Define FPC_GEN_SYNC_ERR_CNT_EN to add a saturating o_sync_err pulse counter with i_clr_cnt.
module fpc_gen #(
   parameter int ROWS = 4,
   parameter int COLS = 1041,
   parameter int OH_COLS = 16,
   parameter int MAP_MODE = 1,
   parameter int MFAS_W = 8,
   localparam int ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1,
   localparam int COL_W = $clog2(COLS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_valid,
   input  logic              i_sync,
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
   input  logic              i_clr_cnt,
   output logic [15:0]       o_sync_err_cnt,
`endif
   output logic [ROW_W-1:0]  o_row_cnt,
   output logic [COL_W-1:0]  o_col_cnt,
   output logic [MFAS_W-1:0] o_mfas,
   output logic              o_adv,
   output logic              o_oh,
   output logic              o_sof,
   output logic              o_eof,
   output logic              o_sync_err
);
   if (MAP_MODE != 0 && MAP_MODE != 1) begin : g_bad_mode
      $error("fpc_gen: MAP_MODE must be 0 or 1");
   end
   logic last_col, last_row, free_col, sync;
   always_comb begin
      last_col = o_col_cnt == COL_W'(COLS - 1);
      last_row = o_row_cnt == ROW_W'(ROWS - 1);
      free_col = o_oh | last_col;
      sync     = i_enable & i_sync;
      o_oh     = o_col_cnt < COL_W'(OH_COLS);
      o_sof    = o_row_cnt == '0 && o_col_cnt == '0;
      o_eof    = last_row & last_col;
      o_adv    = i_enable & (i_valid | ((MAP_MODE == 1) & free_col));
   end
   // sync treats the current beat as row 0/col 0, so the next beat lands on col 1
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_row_cnt  <= '0;
         o_col_cnt  <= '0;
         o_mfas     <= '0;
         o_sync_err <= 1'b0;
      end else begin
         o_sync_err <= sync & ~o_sof;
         if (sync) begin
            o_row_cnt <= '0;
            o_col_cnt <= COL_W'(1);
         end else if (o_adv) begin
            o_col_cnt <= last_col ? '0 : o_col_cnt + COL_W'(1);
            if (last_col) o_row_cnt <= last_row ? '0 : o_row_cnt + ROW_W'(1);
            if (o_eof) o_mfas <= o_mfas + MFAS_W'(1);
         end
      end
   end
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_sync_err_cnt <= '0;
      else if (i_clr_cnt) o_sync_err_cnt <= '0;
      else if (o_sync_err && o_sync_err_cnt != 16'hFFFF) o_sync_err_cnt <= o_sync_err_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_fpc_gen.sv
// tb_fpc_gen: directed table-driven bench for fpc_gen (demap, map and small-frame instances).
module tb_fpc_gen;
   logic clk, rst, en, va, sy;
   logic [1:0]  dm_row, mp_row;
   logic [10:0] dm_col, mp_col;
   logic [7:0]  dm_mfas, mp_mfas;
   logic        dm_adv, dm_oh, dm_sof, dm_eof, dm_serr;
   logic        mp_adv, mp_oh, mp_sof, mp_eof, mp_serr;
   logic [0:0]  sm_row;
   logic [4:0]  sm_col;
   logic [1:0]  sm_mfas;
   logic        sm_adv, sm_oh, sm_sof, sm_eof, sm_serr;
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
   logic        clr;
   logic [15:0] dm_cnt, mp_cnt, sm_cnt;
`endif
   int checks = 0, passed = 0;

   fpc_gen #(.MAP_MODE(0)) u_dm (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(va), .i_sync(sy),
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
      .i_clr_cnt(clr), .o_sync_err_cnt(dm_cnt),
`endif
      .o_row_cnt(dm_row), .o_col_cnt(dm_col), .o_mfas(dm_mfas), .o_adv(dm_adv),
      .o_oh(dm_oh), .o_sof(dm_sof), .o_eof(dm_eof), .o_sync_err(dm_serr));

   fpc_gen #(.MAP_MODE(1)) u_mp (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(va), .i_sync(sy),
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
      .i_clr_cnt(clr), .o_sync_err_cnt(mp_cnt),
`endif
      .o_row_cnt(mp_row), .o_col_cnt(mp_col), .o_mfas(mp_mfas), .o_adv(mp_adv),
      .o_oh(mp_oh), .o_sof(mp_sof), .o_eof(mp_eof), .o_sync_err(mp_serr));

   fpc_gen #(.ROWS(2), .COLS(20), .OH_COLS(4), .MAP_MODE(1), .MFAS_W(2)) u_sm (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(va), .i_sync(sy),
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
      .i_clr_cnt(clr), .o_sync_err_cnt(sm_cnt),
`endif
      .o_row_cnt(sm_row), .o_col_cnt(sm_col), .o_mfas(sm_mfas), .o_adv(sm_adv),
      .o_oh(sm_oh), .o_sof(sm_sof), .o_eof(sm_eof), .o_sync_err(sm_serr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0; va = 1'b0; sy = 1'b0;
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
      clr = 1'b0;
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      bit en, va, sy, adv;
      int row, col;
      bit serr, oh, sof, eof;
   } vec_t;
   vec_t vt[13];

   initial begin
      // small frame 2x20, OH 0..3, map mode; starts from reset at row0/col0
      vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0};

      do_reset();
      chk("rst_row", dm_row, 0);
      chk("rst_col", dm_col, 0);
      chk("rst_mfas", dm_mfas, 0);
      chk("rst_sof", dm_sof, 1);
      chk("rst_oh", dm_oh, 1);
      chk("rst_eof", dm_eof, 0);
      chk("rst_serr", dm_serr, 0);

      // demap full multiframe walk
      en = 1'b1; va = 1'b1;
      for (int i = 1; i <= 4164; i++) begin
         automatic int p = i % 4164;
         tick();
         chk("t1_row", dm_row, p / 1041);
         chk("t1_col", dm_col, p % 1041);
         chk("t1_mfas", dm_mfas, i / 4164);
         chk("t1_eof", dm_eof, p == 4163);
         chk("t1_oh", dm_oh, (p % 1041) < 16);
      end
      va = 1'b0;
      #1 chk("t1_adv_novalid", dm_adv, 0);
      tick();
      chk("t1_hold_col", dm_col, 0);

      // enable low at eof holds everything, even with valid and sync
      do_reset();
      en = 1'b1; va = 1'b1;
      tick(4163);
      chk("t3_row", dm_row, 3);
      chk("t3_col", dm_col, 1040);
      chk("t3_eof", dm_eof, 1);
      en = 1'b0; sy = 1'b1;
      #1 chk("t3_adv", dm_adv, 0);
      tick();
      chk("t3_hold_row", dm_row, 3);
      chk("t3_hold_col", dm_col, 1040);
      chk("t3_hold_mfas", dm_mfas, 0);
      chk("t3_no_serr", dm_serr, 0);

      // bad sync mid-frame, mfas preserved
      en = 1'b1; sy = 1'b0;
      tick();
      chk("t4_wrap_mfas", dm_mfas, 1);
      tick(2582);
      chk("t4_pre_row", dm_row, 2);
      chk("t4_pre_col", dm_col, 500);
      sy = 1'b1;
      tick();
      chk("t4_sync_row", dm_row, 0);
      chk("t4_sync_col", dm_col, 1);
      chk("t4_sync_mfas", dm_mfas, 1);
      chk("t4_serr", dm_serr, 1);
      sy = 1'b0;
      tick();
      chk("t4_serr_pulse", dm_serr, 0);
      chk("t4_next_col", dm_col, 2);
      va = 1'b0; sy = 1'b1;
      tick();
      chk("t4_novalid_sync_col", dm_col, 1);
      chk("t4_novalid_serr", dm_serr, 1);
      sy = 1'b0;
      tick();
      chk("t4_novalid_hold", dm_col, 1);
      do_reset();
      en = 1'b1; va = 1'b1; sy = 1'b1;
      tick();
      chk("t4_good_sync_col", dm_col, 1);
      chk("t4_good_sync_serr", dm_serr, 0);
      sy = 1'b0;

      // async reset between edges
      do_reset();
      en = 1'b1; va = 1'b1;
      tick(1741);
      chk("t5_pre_row", dm_row, 1);
      chk("t5_pre_col", dm_col, 700);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_row", dm_row, 0);
      chk("t5_async_col", dm_col, 0);
      chk("t5_async_sof", dm_sof, 1);
      #2 rst = 1'b0;
      tick();
      chk("t5_resume_col", dm_col, 1);
      chk("t5_resume_row", dm_row, 0);

      // map mode: OH free-runs, payload waits for valid, justification column free-runs
      do_reset();
      en = 1'b1; va = 1'b0;
      tick(30);
      chk("t2_oh_stop_col", mp_col, 16);
      chk("t2_adv_stall", mp_adv, 0);
      va = 1'b1;
      tick(1024);
      chk("t2_just_col", mp_col, 1040);
      va = 1'b0;
      #1 chk("t2_adv_just", mp_adv, 1);
      tick();
      chk("t2_wrap_row", mp_row, 1);
      chk("t2_wrap_col", mp_col, 0);
      tick();
      chk("t2_oh_col", mp_col, 1);

      // small frame vector table
      do_reset();
      foreach (vt[i]) begin
         en = vt[i].en; va = vt[i].va; sy = vt[i].sy;
         #1 chk($sformatf("v%0d_adv", i), sm_adv, vt[i].adv);
         tick();
         chk($sformatf("v%0d_row", i), sm_row, vt[i].row);
         chk($sformatf("v%0d_col", i), sm_col, vt[i].col);
         chk($sformatf("v%0d_serr", i), sm_serr, vt[i].serr);
         chk($sformatf("v%0d_oh", i), sm_oh, vt[i].oh);
         chk($sformatf("v%0d_sof", i), sm_sof, vt[i].sof);
         chk($sformatf("v%0d_eof", i), sm_eof, vt[i].eof);
      end
`ifdef FPC_GEN_SYNC_ERR_CNT_EN
      chk("cnt_three", sm_cnt, 3);
      clr = 1'b1;
      tick();
      chk("cnt_clr", sm_cnt, 0);
      clr = 1'b0; en = 1'b1; va = 1'b1; sy = 1'b1;
      tick();
      sy = 1'b0; en = 1'b0; clr = 1'b1;
      tick();
      chk("cnt_clr_wins", sm_cnt, 0);
      clr = 1'b0;
      tick();
      chk("cnt_after_clr", sm_cnt, 0);
`endif

      // small-frame multiframe roll over 5 frames
      do_reset();
      en = 1'b1; va = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(39);
         chk("t6_eof", sm_eof, 1);
         tick();
         chk("t6_mfas", sm_mfas, k % 4);
         chk("t6_sof", sm_sof, 1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
